pitch_count_ctrl: RTL and testbench
===================================

# pitch_count_ctrl

Sequencer for the ball/strike/out scoreboard. It accepts one-cycle pitch-outcome pulses and maintains the ball (0–3), strike (0–2) and out (0–2) counts as thermometer LED vectors. It detects walks, strikeouts and third outs, holds the final count on the display for a programmable time, then clears the counts and advances the inning half. It sits between the pitch-entry debouncers and the scoreboard LED drivers.

## Interface
- HOLD_CYCLES, default 4: display-hold duration after walk, strikeout or third out; legal range 1 to 2^24−1.
- iCLK  in  1  system clock, all logic on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iCLR  in  1  synchronous game clear; same effect as iRST.
- iBALL  in  1  one-cycle pulse, ball called.
- iSTRIKE  in  1  one-cycle pulse, strike called.
- iFOUL  in  1  one-cycle pulse, foul ball.
- iHIT  in  1  one-cycle pulse, batter reached base on a hit.
- iOUT  in  1  one-cycle pulse, batter put out in the field.
- oBALL  out  3  thermometer ball count: 000, 001, 011, 111.
- oSTRIKE  out  2  thermometer strike count: 00, 01, 11.
- oOUT  out  2  thermometer out count: 00, 01, 11.
- oWALK  out  1  one-cycle pulse on ball four.
- oKOUT  out  1  one-cycle pulse on strike three.
- oSIDE  out  1  one-cycle pulse on third out.
- oTOP  out  1  1 = top half of the inning, 0 = bottom half.
- oBUSY  out  1  high while in a hold state.

## Operation
- Reset (iRST or iCLR) values:
  - State COUNT, all internal counts 0, hold counter 0.
  - oBALL, oSTRIKE and oOUT are 0.
  - oWALK, oKOUT, oSIDE and oBUSY are 0.
  - oTOP is 1.
- iCLR is ignored while iRST is high.
- Event priority: at most one event is processed per cycle, in the order iOUT > iHIT > iSTRIKE > iBALL > iFOUL. Lower-priority pulses in the same cycle are discarded.
- States: COUNT, HOLD_BAT, HOLD_SIDE.
- In COUNT:
  - iBALL with balls < 3: balls += 1.
  - iBALL with balls = 3: oWALK pulses, oBALL is forced to 111, go to HOLD_BAT.
  - iSTRIKE with strikes < 2: strikes += 1.
  - iSTRIKE with strikes = 2: oKOUT pulses and outs += 1.
    - If the new out total is below 3: go to HOLD_BAT.
    - If it reaches 3: oSIDE also pulses and go to HOLD_SIDE.
  - iHIT: balls and strikes cleared immediately; no hold; outs unchanged.
  - iOUT: balls and strikes cleared; outs += 1.
    - If outs reach 3: oSIDE pulses, go to HOLD_SIDE.
    - Otherwise stay in COUNT.
  - iFOUL: see Configuration.
- Display during holds:
  - HOLD_BAT: the final ball/strike display is frozen.
  - HOLD_SIDE: oOUT shows 11, and the ball/strike display is frozen at its value in the cycle the third out occurred.
  - In both hold states oBUSY = 1 and all pitch inputs are ignored (dropped, not queued).
- Hold counter:
  - Loads 0 on entry and increments each cycle.
  - On reaching HOLD_CYCLES−1 the state exits to COUNT.
  - Exit from HOLD_BAT clears balls and strikes; outs are kept.
  - Exit from HOLD_SIDE clears balls, strikes and outs, and toggles oTOP.
- Internal counts never exceed 3 balls, 2 strikes or 2 outs while in COUNT.

## Timing
- All outputs are registered. An event pulse sampled at edge N is visible on the outputs after edge N; this is one cycle of latency.
- oWALK, oKOUT and oSIDE are high for exactly one cycle: the first cycle of the resulting hold state.
- oBUSY rises in the same cycle as the event pulse outputs.
- oBUSY stays high for exactly HOLD_CYCLES cycles, then falls together with the count clear and the oTOP toggle.
- An event arriving in the first cycle after exit to COUNT is accepted.
- iRST or iCLR during a hold aborts the hold: all values are restored to their reset values on the next edge, including oTOP = 1.

## Configuration
- FOUL_STRIKE_EN defined: iFOUL is treated as a strike while strikes < 2. With strikes = 2, iFOUL has no effect; a foul never causes a strikeout.
- FOUL_STRIKE_EN undefined: iFOUL is ignored entirely. The port remains present.

## Test plan
All scenarios use HOLD_CYCLES = 4.
- Reset check: assert iRST for 2 cycles. Outputs read oBALL = 000, oSTRIKE = 00, oOUT = 00, oTOP = 1, and all pulses and oBUSY are 0.
- Walk:
  - 4 iBALL pulses give oBALL = 001, 011, 111.
  - On the 4th pulse, oWALK pulses once and oBUSY is high for 4 cycles.
  - Afterwards oBALL = 000 and oOUT is unchanged.
- Strikeouts and side retirement:
  - Three strikeouts in a row. Each gives an oKOUT pulse.
  - The third strikeout also gives an oSIDE pulse.
  - After the HOLD_SIDE exit: oOUT = 00, oTOP = 0.
- Simultaneous events and held inputs:
  - From a 2-1 count, pulse iBALL and iSTRIKE together. Only the strike is applied: oSTRIKE = 11, oBALL = 011.
  - During a hold, pulse iBALL. It is ignored, and the count after the hold is 000/00.
- Foul ball:
  - With FOUL_STRIKE_EN: iFOUL ×3 gives oSTRIKE = 01, 11, 11 and no oKOUT.
  - Without the macro: oSTRIKE stays 00.
- Clear mid-hold: iCLR in the 2nd cycle of HOLD_SIDE returns all outputs to their reset values next cycle, with oTOP = 1 and oBUSY = 0.

Source files
------------

// File: rtl/pitch_count_ctrl_if.sv
// pitch_count_ctrl_if
//   Bundles the pitch-outcome pulses from the debouncers and the scoreboard
//   display/status outputs of pitch_count_ctrl.
//   master : pitch-entry side (drives i* pulses, observes o* outputs)
//   slave  : pitch_count_ctrl (samples i* pulses, drives o* outputs)
//   Signals:
//     iBALL, iSTRIKE, iFOUL, iHIT, iOUT : one-cycle pitch-outcome pulses
//     oBALL[2:0], oSTRIKE[1:0], oOUT[1:0] : thermometer count displays
//     oWALK, oKOUT, oSIDE : one-cycle event pulses
//     oTOP : 1 = top half of inning, oBUSY : hold in progress
interface pitch_count_ctrl_if;
    logic       iBALL;
    logic       iSTRIKE;
    logic       iFOUL;
    logic       iHIT;
    logic       iOUT;
    logic [2:0] oBALL;
    logic [1:0] oSTRIKE;
    logic [1:0] oOUT;
    logic       oWALK;
    logic       oKOUT;
    logic       oSIDE;
    logic       oTOP;
    logic       oBUSY;

    modport master (
        output iBALL, iSTRIKE, iFOUL, iHIT, iOUT,
        input  oBALL, oSTRIKE, oOUT, oWALK, oKOUT, oSIDE, oTOP, oBUSY
    );

    modport slave (
        input  iBALL, iSTRIKE, iFOUL, iHIT, iOUT,
        output oBALL, oSTRIKE, oOUT, oWALK, oKOUT, oSIDE, oTOP, oBUSY
    );
endinterface

// File: rtl/pitch_count_ctrl.sv
// pitch_count_ctrl
//   Ball/strike/out sequencer for the scoreboard. Accepts one-cycle pitch
//   pulses, keeps the counts, detects walk / strikeout / third out, holds
//   the final count for HOLD_CYCLES cycles, then clears and (after a third
//   out) advances the inning half.
//   Ports:
//     iCLK : clock, rising edge
//     iRST : synchronous active-high reset
//     iCLR : synchronous game clear, same effect as iRST
//     pc   : pitch_count_ctrl_if.slave (pitch pulses in, displays/pulses out)
//   Parameter:
//     HOLD_CYCLES : display-hold length, 1 .. 2^24-1 (default 4)
//   Build option:
//     FOUL_STRIKE_EN : when defined, a foul counts as a strike below two
//                      strikes; otherwise iFOUL is ignored.
module pitch_count_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCLR,
    pitch_count_ctrl_if.slave pc
);

    typedef enum logic [1:0] {
        COUNT     = 2'd0,
        HOLD_BAT  = 2'd1,
        HOLD_SIDE = 2'd2
    } state_t;

    localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);

    state_t      state, stateNext;
    logic [1:0]  balls, ballsNext;
    logic [1:0]  strikes, strikesNext;
    logic [1:0]  outs, outsNext;
    logic [23:0] holdCnt, holdCntNext;
    logic        top, topNext;
    logic        walkNext, koutNext, sideNext;

    always_comb begin
        stateNext   = state;
        ballsNext   = balls;
        strikesNext = strikes;
        outsNext    = outs;
        holdCntNext = holdCnt;
        topNext     = top;
        walkNext    = 1'b0;
        koutNext    = 1'b0;
        sideNext    = 1'b0;

        case (state)
            COUNT: begin
                if (pc.iOUT) begin
                    if (outs == 2'd2) begin
                        // Third out: counts stay untouched so the display
                        // keeps the pre-out ball/strike value until exit.
                        sideNext    = 1'b1;
                        stateNext   = HOLD_SIDE;
                        holdCntNext = '0;
                    end else begin
                        ballsNext   = '0;
                        strikesNext = '0;
                        outsNext    = outs + 2'd1;
                    end
                end else if (pc.iHIT) begin
                    ballsNext   = '0;
                    strikesNext = '0;
                end else if (pc.iSTRIKE) begin
                    if (strikes < 2'd2) begin
                        strikesNext = strikes + 2'd1;
                    end else begin
                        koutNext    = 1'b1;
                        holdCntNext = '0;
                        if (outs == 2'd2) begin
                            sideNext  = 1'b1;
                            stateNext = HOLD_SIDE;
                        end else begin
                            outsNext  = outs + 2'd1;
                            stateNext = HOLD_BAT;
                        end
                    end
                end else if (pc.iBALL) begin
                    if (balls < 2'd3) begin
                        ballsNext = balls + 2'd1;
                    end else begin
                        walkNext    = 1'b1;
                        holdCntNext = '0;
                        stateNext   = HOLD_BAT;
                    end
                end else if (pc.iFOUL) begin
`ifdef FOUL_STRIKE_EN
                    if (strikes < 2'd2) begin
                        strikesNext = strikes + 2'd1;
                    end
`else
                    strikesNext = strikes;
`endif
                end
            end

            HOLD_BAT, HOLD_SIDE: begin
                if (holdCnt == HOLD_LAST) begin
                    stateNext   = COUNT;
                    ballsNext   = '0;
                    strikesNext = '0;
                    if (state == HOLD_SIDE) begin
                        outsNext = '0;
                        topNext  = ~top;
                    end
                end else begin
                    holdCntNext = holdCnt + 24'd1;
                end
            end

            default: stateNext = COUNT;
        endcase
    end

    // Outputs are registered from the next-state values so every display
    // change appears exactly one edge after the pulse that caused it.
    always_ff @(posedge iCLK) begin
        if (iRST || iCLR) begin
            state      <= COUNT;
            balls      <= '0;
            strikes    <= '0;
            outs       <= '0;
            holdCnt    <= '0;
            top        <= 1'b1;
            pc.oBALL   <= '0;
            pc.oSTRIKE <= '0;
            pc.oOUT    <= '0;
            pc.oWALK   <= 1'b0;
            pc.oKOUT   <= 1'b0;
            pc.oSIDE   <= 1'b0;
            pc.oTOP    <= 1'b1;
            pc.oBUSY   <= 1'b0;
        end else begin
            state      <= stateNext;
            balls      <= ballsNext;
            strikes    <= strikesNext;
            outs       <= outsNext;
            holdCnt    <= holdCntNext;
            top        <= topNext;
            pc.oBALL   <= {ballsNext == 2'd3, ballsNext >= 2'd2, ballsNext >= 2'd1};
            pc.oSTRIKE <= {strikesNext >= 2'd2, strikesNext >= 2'd1};
            pc.oOUT    <= (stateNext == HOLD_SIDE) ? 2'b11
                        : {outsNext >= 2'd2, outsNext >= 2'd1};
            pc.oWALK   <= walkNext;
            pc.oKOUT   <= koutNext;
            pc.oSIDE   <= sideNext;
            pc.oTOP    <= topNext;
            pc.oBUSY   <= (stateNext != COUNT);
        end
    end

endmodule

// File: tb/tb_pitch_count_ctrl.sv
// tb_pitch_count_ctrl
//   Directed vector table for the scoreboard scenarios plus a randomized run,
//   every cycle checked against a count-level reference model.
module tb_pitch_count_ctrl;

    localparam int HOLD = 4;

`ifdef FOUL_STRIKE_EN
    localparam int F1 = 1;
    localparam int F2 = 3;
`else
    localparam int F1 = 0;
    localparam int F2 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;

    pitch_count_ctrl_if pif ();

    pitch_count_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .iCLK(clk),
        .iRST(rst),
        .iCLR(clr),
        .pc  (pif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: counts as integers, hold as a countdown of remaining
    // busy cycles.
    int mBalls, mStrikes, mOuts, mTop, mHoldLeft, mSideHold;
    int mWalk, mKout, mSide;

    typedef struct {
        bit r, c, b, s, f, h, o;
        int eBall, eStrike, eOut, eWalk, eKout, eSide, eTop, eBusy;
    } vec_t;

    vec_t vecs[$];

    task automatic addV(input bit r, c, b, s, f, h, o,
                        input int eb, es, eo, ew, ek, esd, et, ebz);
        vec_t v;
        v.r = r; v.c = c; v.b = b; v.s = s; v.f = f; v.h = h; v.o = o;
        v.eBall = eb; v.eStrike = es; v.eOut = eo; v.eWalk = ew;
        v.eKout = ek; v.eSide = esd; v.eTop = et; v.eBusy = ebz;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, c, b, s, f, h, o);
        mWalk = 0; mKout = 0; mSide = 0;
        if (r || c) begin
            mBalls = 0; mStrikes = 0; mOuts = 0; mTop = 1;
            mHoldLeft = 0; mSideHold = 0;
        end else if (mHoldLeft > 0) begin
            mHoldLeft--;
            if (mHoldLeft == 0) begin
                mBalls = 0; mStrikes = 0;
                if (mSideHold != 0) begin
                    mOuts = 0; mTop = 1 - mTop; mSideHold = 0;
                end
            end
        end else if (o) begin
            if (mOuts + 1 == 3) begin
                mSide = 1; mSideHold = 1; mHoldLeft = HOLD;
            end else begin
                mBalls = 0; mStrikes = 0; mOuts++;
            end
        end else if (h) begin
            mBalls = 0; mStrikes = 0;
        end else if (s) begin
            if (mStrikes < 2) mStrikes++;
            else begin
                mKout = 1; mHoldLeft = HOLD;
                if (mOuts + 1 == 3) begin
                    mSide = 1; mSideHold = 1;
                end else begin
                    mOuts++;
                end
            end
        end else if (b) begin
            if (mBalls < 3) mBalls++;
            else begin
                mWalk = 1; mHoldLeft = HOLD;
            end
        end else if (f) begin
`ifdef FOUL_STRIKE_EN
            if (mStrikes < 2) mStrikes++;
`endif
        end
    endtask

    task automatic checkModel();
        int eOut;
        eOut = (mHoldLeft > 0 && mSideHold != 0) ? 3 : (1 << mOuts) - 1;
        check("model.oBALL",   int'(pif.oBALL),   (1 << mBalls) - 1);
        check("model.oSTRIKE", int'(pif.oSTRIKE), (1 << mStrikes) - 1);
        check("model.oOUT",    int'(pif.oOUT),    eOut);
        check("model.oWALK",   int'(pif.oWALK),   mWalk);
        check("model.oKOUT",   int'(pif.oKOUT),   mKout);
        check("model.oSIDE",   int'(pif.oSIDE),   mSide);
        check("model.oTOP",    int'(pif.oTOP),    mTop);
        check("model.oBUSY",   int'(pif.oBUSY),   (mHoldLeft > 0) ? 1 : 0);
    endtask

    // Called on a negative edge: drive, clock, update model, check on next negedge.
    task automatic step(input bit r, c, b, s, f, h, o);
        rst = r; clr = c;
        pif.iBALL = b; pif.iSTRIKE = s; pif.iFOUL = f; pif.iHIT = h; pif.iOUT = o;
        @(posedge clk);
        modelStep(r, c, b, s, f, h, o);
        @(negedge clk);
        checkModel();
    endtask

    initial begin
        pif.iBALL = 0; pif.iSTRIKE = 0; pif.iFOUL = 0; pif.iHIT = 0; pif.iOUT = 0;

        //    r c b s f h o   ball str out wlk k sd top busy
        addV(1,0,0,0,0,0,0,   0, 0, 0, 0,0,0, 1, 0);
        addV(1,0,0,0,0,0,0,   0, 0, 0, 0,0,0, 1, 0);
        // walk
        addV(0,0,1,0,0,0,0,   1, 0, 0, 0,0,0, 1, 0);
        addV(0,0,1,0,0,0,0,   3, 0, 0, 0,0,0, 1, 0);
        addV(0,0,1,0,0,0,0,   7, 0, 0, 0,0,0, 1, 0);
        addV(0,0,1,0,0,0,0,   7, 0, 0, 1,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   7, 0, 0, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   7, 0, 0, 0,0,0, 1, 1);
        addV(0,0,1,0,0,0,0,   7, 0, 0, 0,0,0, 1, 1);  // ball ignored in hold
        addV(0,0,0,0,0,0,0,   0, 0, 0, 0,0,0, 1, 0);
        // 2-1 count, then ball+strike together
        addV(0,0,1,0,0,0,0,   1, 0, 0, 0,0,0, 1, 0);
        addV(0,0,1,0,0,0,0,   3, 0, 0, 0,0,0, 1, 0);
        addV(0,0,0,1,0,0,0,   3, 1, 0, 0,0,0, 1, 0);
        addV(0,0,1,1,0,0,0,   3, 3, 0, 0,0,0, 1, 0);
        addV(0,0,0,0,0,1,0,   0, 0, 0, 0,0,0, 1, 0);
        // strikeout 1
        addV(0,0,0,1,0,0,0,   0, 1, 0, 0,0,0, 1, 0);
        addV(0,0,0,1,0,0,0,   0, 3, 0, 0,0,0, 1, 0);
        addV(0,0,0,1,0,0,0,   0, 3, 1, 0,1,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 3, 1, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 3, 1, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 3, 1, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 0, 1, 0,0,0, 1, 0);
        // strikeout 2
        addV(0,0,0,1,0,0,0,   0, 1, 1, 0,0,0, 1, 0);
        addV(0,0,0,1,0,0,0,   0, 3, 1, 0,0,0, 1, 0);
        addV(0,0,0,1,0,0,0,   0, 3, 3, 0,1,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 3, 3, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 3, 3, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 3, 3, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 0, 3, 0,0,0, 1, 0);
        // strikeout 3 retires the side
        addV(0,0,0,1,0,0,0,   0, 1, 3, 0,0,0, 1, 0);
        addV(0,0,0,1,0,0,0,   0, 3, 3, 0,0,0, 1, 0);
        addV(0,0,0,1,0,0,0,   0, 3, 3, 0,1,1, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 3, 3, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 3, 3, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 3, 3, 0,0,0, 1, 1);
        addV(0,0,0,0,0,0,0,   0, 0, 0, 0,0,0, 0, 0);
        // fouls
        addV(0,0,0,0,1,0,0,   0, F1, 0, 0,0,0, 0, 0);
        addV(0,0,0,0,1,0,0,   0, F2, 0, 0,0,0, 0, 0);
        addV(0,0,0,0,1,0,0,   0, F2, 0, 0,0,0, 0, 0);
        addV(0,0,0,0,0,1,0,   0, 0, 0, 0,0,0, 0, 0);
        // three field outs, clear in 2nd hold cycle
        addV(0,0,0,0,0,0,1,   0, 0, 1, 0,0,0, 0, 0);
        addV(0,0,0,0,0,0,1,   0, 0, 3, 0,0,0, 0, 0);
        addV(0,0,0,0,0,0,1,   0, 0, 3, 0,0,1, 0, 1);
        addV(0,1,0,0,0,0,0,   0, 0, 0, 0,0,0, 1, 0);
        addV(0,0,0,0,0,0,0,   0, 0, 0, 0,0,0, 1, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            step(v.r, v.c, v.b, v.s, v.f, v.h, v.o);
            check($sformatf("vec%0d.oBALL", i),   int'(pif.oBALL),   v.eBall);
            check($sformatf("vec%0d.oSTRIKE", i), int'(pif.oSTRIKE), v.eStrike);
            check($sformatf("vec%0d.oOUT", i),    int'(pif.oOUT),    v.eOut);
            check($sformatf("vec%0d.oWALK", i),   int'(pif.oWALK),   v.eWalk);
            check($sformatf("vec%0d.oKOUT", i),   int'(pif.oKOUT),   v.eKout);
            check($sformatf("vec%0d.oSIDE", i),   int'(pif.oSIDE),   v.eSide);
            check($sformatf("vec%0d.oTOP", i),    int'(pif.oTOP),    v.eTop);
            check($sformatf("vec%0d.oBUSY", i),   int'(pif.oBUSY),   v.eBusy);
        end

        // iRST wins together with iCLR and pitch pulses
        step(1, 1, 1, 1, 1, 1, 1);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            step(r == 0, r == 1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
